pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined, multi-mode barrel shifter. Successor to the 32-bit combinational left/right shifter. It adds logical/arithmetic/rotate modes, a carry-out and zero flag, one register stage per shift level, and a valid/ready handshake with full backpressure. It is intended to sit between an operand source and an ALU write-back stage.

## Interface
- `WIDTH`, default 32: data width. Must be a power of two, 4 to 128.
- `AMT_W`, default `$clog2(WIDTH)`: derived shift-amount width. Never overridden.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. Release is synchronous to `clk` by the integrator.
- `in_valid` input 1: input operation valid.
- `in_ready` output 1: block can accept an operation this cycle.
- `in_data` input `WIDTH`: operand.
- `in_amt` input `AMT_W`: shift amount, 0 to `WIDTH`-1.
- `in_op` input 3: operation code.
  - 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR.
  - 101 to 111 are reserved.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output `WIDTH`: shifted result.
- `out_carry` output 1: carry/last-out bit.
- `out_zero` output 1: high when `out_data` == 0.

## Operation
- **Transfers.** A transfer occurs on any edge where valid and ready are both high on that interface.
- **Pipeline structure.** The pipeline has `AMT_W` stages. Stage k (k = 0 to `AMT_W`-1) applies a shift of 2^k when `amt[k]` = 1, using the op's fill rule.
  - Each stage holds one valid bit plus data, amt, op and carry registers.
- **Fill rules.**
  - LSL and LSR: zero fill.
  - ASR: fill with the original bit `WIDTH`-1.
  - ROL and ROR: wrap-around fill.
- **Final result for total amount n.**
  - LSL: `data << n`. Carry = original bit `WIDTH`-n.
  - LSR: `data >> n`. Carry = original bit n-1.
  - ASR: sign-extended shift. Carry = original bit n-1.
  - ROL: rotate left. Carry = `result[0]`.
  - ROR: rotate right. Carry = `result[WIDTH-1]`.
  - n = 0, any op: `result = data`, carry = 0.
- **Reserved ops.** `result = data` regardless of `in_amt`, carry = 0. The op is otherwise accepted and retired normally.
- **Zero flag.** `out_zero` is computed from the final-stage data. It is valid whenever `out_valid` is high.
- **Elastic pipeline.**
  - Stage k loads from stage k-1 when stage k is empty, or when stage k is emptying this cycle.
  - The last stage empties when `out_valid && out_ready`.
  - Bubbles collapse; the pipeline never stalls while a downstream stage is empty.
- **Input ready.** `in_ready` = stage 0 empty OR stage 0 advancing this cycle. It depends combinationally on `out_ready` through the chain. No combinational path from `in_valid` to `in_ready`.
- **Ordering and capacity.** Operations retire in acceptance order, with no loss or duplication. Capacity is `AMT_W` operations in flight.
- **Output stability.** While `out_valid` is high and `out_ready` is low, `out_data`, `out_carry` and `out_zero` hold stable.
- **Simultaneous events.** A full pipeline with `out_ready` = 1 and `in_valid` = 1 accepts and retires in the same cycle, sustaining 1 op/cycle.

## Timing
- **Reset values.** During reset, all stage valid bits are 0.
  - `out_valid` = 0.
  - `in_ready` = 1 (when `out_ready` is irrelevant).
  - `out_data` = 0, `out_carry` = 0, `out_zero` = 1.
- **Latency.** An op accepted at edge t presents `out_valid` after edge t+`AMT_W`, provided no backpressure. For `WIDTH` = 32 this is 5 cycles.
- **Throughput.** 1 op/cycle in steady state with `out_ready` held high.
- **Fill under backpressure.** With `out_ready` low, the pipeline accepts exactly `AMT_W` ops. `in_ready` then drops in the cycle after the `AMT_W`-th acceptance.
- **Reset mid-operation.** Asserting `rst_n` low discards all in-flight ops immediately, asynchronously. No partial result appears after release.

## Test plan
- **LSL with carry.** LSL, `in_data` 0x0000003F, amt 27 -> `out_data` 0xF8000000, carry 1, zero 0, 5 cycles after acceptance.
- **ASR sign fill.** ASR, `in_data` 0x80000000, amt 19 -> 0xFFFFF000, carry 0. Same operand with LSR -> 0x00001000, carry 0.
- **Rotates.**
  - ROR 0x0000000F by 4 -> 0xF0000000, carry 1.
  - ROL 0x80000001 by 1 -> 0x00000003, carry 1.
  - Any op with amt 0 on 0x12345678 -> 0x12345678, carry 0.
- **Zero flag and reserved ops.** LSR 0x0000000F by 19 -> 0x00000000, zero 1, carry 0. Reserved op 101 with 0xA5A5A5A5 amt 7 -> 0xA5A5A5A5, carry 0.
- **Backpressure and ordering.** Hold `out_ready` low and offer 8 back-to-back ops.
  - Exactly 5 are accepted, then `in_ready` = 0.
  - Toggle `out_ready` randomly: all 8 retire in order with correct results, and outputs stay stable while stalled.
- **Reset mid-operation.** Pull `rst_n` low with 3 ops in flight -> `out_valid` = 0 immediately. After release, a fresh op emerges after exactly 5 cycles with no stale results.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Elastic barrel shifter: one register stage per shift-amount bit, valid/ready on both sides.
// Supports LSL/LSR/ASR/ROL/ROR with carry-out and zero flag; reserved op codes pass data through.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // One partial shift by sh; the carry is the last bit pushed out, which after all
    // stages equals the bit the full-amount shift would have pushed out.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             c,
        input logic [2:0]       op,
        input logic             en,
        input int unsigned      sh
    );
        logic [WIDTH-1:0] r;
        logic             cy;
        r  = d;
        cy = c;
        if (en) begin
            case (op)
                OP_LSL: begin
                    r  = d << sh;
                    cy = |(d & (ONE << (WIDTH - sh)));
                end
                OP_LSR: begin
                    r  = d >> sh;
                    cy = |(d & (ONE << (sh - 1)));
                end
                OP_ASR: begin
                    r  = $unsigned($signed(d) >>> sh);
                    cy = |(d & (ONE << (sh - 1)));
                end
                OP_ROL: begin
                    r  = (d << sh) | (d >> (WIDTH - sh));
                    cy = r[0];
                end
                OP_ROR: begin
                    r  = (d >> sh) | (d << (WIDTH - sh));
                    cy = r[WIDTH-1];
                end
                default: begin
                    r  = d;
                    cy = c;
                end
            endcase
        end
        return {cy, r};
    endfunction

    logic             valid_q [AMT_W];
    logic [WIDTH-1:0] data_q  [AMT_W];
    logic             carry_q [AMT_W];
    logic [AMT_W-1:0] amt_q   [AMT_W];
    logic [2:0]       op_q    [AMT_W];

    logic [AMT_W-1:0] valid_vec;
    logic [AMT_W-1:0] load;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             src_carry;
        logic [AMT_W-1:0] src_amt;
        logic [2:0]       src_op;
        logic [WIDTH:0]   res_d;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_carry = 1'b0;
            assign src_amt   = in_amt;
            assign src_op    = in_op;
        end else begin : g_body
            assign src_valid = valid_q[k-1];
            assign src_data  = data_q[k-1];
            assign src_carry = carry_q[k-1];
            assign src_amt   = amt_q[k-1];
            assign src_op    = op_q[k-1];
        end

        assign res_d        = shift_step(src_data, src_carry, src_op, src_amt[k], 1 << k);
        assign valid_vec[k] = valid_q[k];
        // A stage can load whenever any stage at or after it has a hole, or the sink drains.
        assign load[k]      = out_ready | ~&valid_vec[AMT_W-1:k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                carry_q[k] <= 1'b0;
                amt_q[k]   <= '0;
                op_q[k]    <= '0;
            end else if (load[k]) begin
                valid_q[k] <= src_valid;
                data_q[k]  <= res_d[WIDTH-1:0];
                carry_q[k] <= res_d[WIDTH];
                amt_q[k]   <= src_amt;
                op_q[k]    <= src_op;
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{amt_q[AMT_W-1], op_q[AMT_W-1]};

    assign in_ready  = load[0];
    assign out_valid = valid_q[AMT_W-1];
    assign out_data  = data_q[AMT_W-1];
    assign out_carry = carry_q[AMT_W-1];
    assign out_zero  = (data_q[AMT_W-1] == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32): directed vectors,
// streaming, random handshakes, backpressure fill/drain and mid-flight reset.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Whole-amount reference: shift into a double-width window and read result and carry from it.
    function automatic logic [32:0] model(input logic [31:0] d, input int n, input logic [2:0] op);
        logic [63:0] w;
        logic [31:0] r;
        logic        c;
        r = d;
        c = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin w = {32'b0, d} << n; r = w[31:0]; c = w[32]; end
                3'd1: begin w = {d, 32'b0} >> n; r = w[63:32]; c = w[31]; end
                3'd2: begin w = $unsigned($signed({d, 32'b0}) >>> n); r = w[63:32]; c = w[31]; end
                3'd3: begin w = {d, d} << n; r = w[63:32]; c = r[0]; end
                3'd4: begin w = {d, d} >> n; r = w[31:0]; c = r[31]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got=%b exp=1", out_zero); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] vd[16]; int va[16]; logic [2:0] vo[16]; logic [31:0] vr[16]; logic vc[16];
        int lat;
        vd[0]  = 32'h0000003F; va[0]  = 27; vo[0]  = 3'd0; vr[0]  = 32'hF8000000; vc[0]  = 1'b1;
        vd[1]  = 32'h80000000; va[1]  = 19; vo[1]  = 3'd2; vr[1]  = 32'hFFFFF000; vc[1]  = 1'b0;
        vd[2]  = 32'h80000000; va[2]  = 19; vo[2]  = 3'd1; vr[2]  = 32'h00001000; vc[2]  = 1'b0;
        vd[3]  = 32'h0000000F; va[3]  = 4;  vo[3]  = 3'd4; vr[3]  = 32'hF0000000; vc[3]  = 1'b1;
        vd[4]  = 32'h80000001; va[4]  = 1;  vo[4]  = 3'd3; vr[4]  = 32'h00000003; vc[4]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vd[5+i] = 32'h12345678; va[5+i] = 0; vo[5+i] = 3'(i); vr[5+i] = 32'h12345678; vc[5+i] = 1'b0;
        end
        vd[10] = 32'h0000000F; va[10] = 19; vo[10] = 3'd1; vr[10] = 32'h00000000; vc[10] = 1'b0;
        vd[11] = 32'hA5A5A5A5; va[11] = 7;  vo[11] = 3'd5; vr[11] = 32'hA5A5A5A5; vc[11] = 1'b0;
        vd[12] = 32'hA5A5A5A5; va[12] = 7;  vo[12] = 3'd7; vr[12] = 32'hA5A5A5A5; vc[12] = 1'b0;
        vd[13] = 32'hFFFFFFFF; va[13] = 31; vo[13] = 3'd0; vr[13] = 32'h80000000; vc[13] = 1'b1;
        vd[14] = 32'h7FFFFFFF; va[14] = 31; vo[14] = 3'd2; vr[14] = 32'h00000000; vc[14] = 1'b1;
        vd[15] = 32'h00000001; va[15] = 31; vo[15] = 3'd4; vr[15] = 32'h00000002; vc[15] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[i]; in_amt = 5'(va[i]); in_op = vo[i]; out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready); end
            lat = 0;
            for (int c = 1; c <= AMT_W + 4 && lat == 0; c++) begin
                @(negedge clk); in_valid = 1'b0; #1;
                if (out_valid === 1'b1) lat = c;
            end
            checks++; if (lat != AMT_W) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, AMT_W); end
            checks++;
            if (out_data !== vr[i] || out_carry !== vc[i] || out_zero !== (vr[i] == 0)) begin
                errors++;
                $display("FAIL dir%0d_result got=%h c=%b z=%b exp=%h c=%b z=%b", i, out_data, out_carry, out_zero,
                         vr[i], vc[i], (vr[i] == 0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, done_at = -1;
        logic [32:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 30; c++) begin
            @(negedge clk);
            if (sent < 30) begin
                in_valid = 1'b1; in_data = $urandom; in_amt = 5'($urandom_range(0, 31)); in_op = 3'($urandom_range(0, 4));
            end else in_valid = 1'b0;
            #1;
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            end
            if (in_valid && in_ready) begin exp_q.push_back(model(in_data, int'(in_amt), in_op)); sent++; end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_spurious got=%h exp=none", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[31:0] || out_carry !== e[32] || out_zero !== (e[31:0] == 0)) begin
                        errors++; $display("FAIL b2b_result got=%h c=%b exp=%h c=%b", out_data, out_carry, e[31:0], e[32]);
                    end
                end
                got++;
                if (got == 30) done_at = c;
            end
        end
        checks++; if (done_at != 34) begin errors++; $display("FAIL b2b_throughput got=%0d exp=34", done_at); end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_random();
        int sent = 0, got = 0;
        logic [32:0] e;
        logic exp_rdy;
        exp_q.delete();
        for (int c = 0; c < 1000 && got < 60; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 6);
            if (sent < 60 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = $urandom; in_amt = 5'($urandom_range(0, 31)); in_op = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 4) == 0) in_data = 32'h0;
            end else in_valid = 1'b0;
            #1;
            exp_rdy = out_ready || (exp_q.size() < AMT_W);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
            if (in_valid && in_ready) begin exp_q.push_back(model(in_data, int'(in_amt), in_op)); sent++; end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_spurious got=%h exp=none", out_data); end
                else begin
                    e = exp_q[0];
                    if (out_data !== e[31:0] || out_carry !== e[32] || out_zero !== (e[31:0] == 0)) begin
                        errors++; $display("FAIL rnd_result got=%h c=%b z=%b exp=%h c=%b", out_data, out_carry, out_zero, e[31:0], e[32]);
                    end
                    if (out_ready) begin void'(exp_q.pop_front()); got++; end
                end
            end
        end
        checks++; if (got != 60) begin errors++; $display("FAIL rnd_retired got=%0d exp=60", got); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        repeat (AMT_W + 1) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] bd[8]; logic [4:0] ba[8]; logic [2:0] bo[8];
        int acc = 0, got = 0;
        logic [32:0] e;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            bd[i] = $urandom; ba[i] = 5'($urandom_range(1, 31)); bo[i] = 3'($urandom_range(0, 4));
        end
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (acc < 8) begin in_valid = 1'b1; in_data = bd[acc]; in_amt = ba[acc]; in_op = bo[acc]; end
            else in_valid = 1'b0;
            #1;
            if (c == AMT_W) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b exp=0", in_ready); end
            end
            if (in_valid && in_ready) begin exp_q.push_back(model(in_data, int'(in_amt), in_op)); acc++; end
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                checks++;
                if (out_data !== e[31:0] || out_carry !== e[32] || out_zero !== (e[31:0] == 0)) begin
                    errors++; $display("FAIL bp_stall_hold got=%h c=%b exp=%h c=%b", out_data, out_carry, e[31:0], e[32]);
                end
            end
        end
        checks++; if (acc != AMT_W) begin errors++; $display("FAIL bp_capacity got=%0d exp=%0d", acc, AMT_W); end
        for (int c = 0; c < 300 && got < 8; c++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (acc < 8) begin in_valid = 1'b1; in_data = bd[acc]; in_amt = ba[acc]; in_op = bo[acc]; end
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin exp_q.push_back(model(in_data, int'(in_amt), in_op)); acc++; end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_spurious got=%h exp=none", out_data); end
                else begin
                    e = exp_q[0];
                    if (out_data !== e[31:0] || out_carry !== e[32] || out_zero !== (e[31:0] == 0)) begin
                        errors++; $display("FAIL bp_order got=%h c=%b exp=%h c=%b", out_data, out_carry, e[31:0], e[32]);
                    end
                    if (out_ready) begin void'(exp_q.pop_front()); got++; end
                end
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL bp_retired got=%0d exp=8", got); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        repeat (AMT_W + 1) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        int lat, stale;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom | 32'h1; in_amt = 5'($urandom_range(0, 31)); in_op = 3'($urandom_range(0, 4));
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got=%b exp=1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_clear got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hC0FFEE01; in_amt = 5'd13; in_op = 3'd4; out_ready = 1'b1;
        e = model(32'hC0FFEE01, 13, 3'd4);
        lat = 0;
        for (int c = 1; c <= AMT_W + 4 && lat == 0; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid === 1'b1) lat = c;
        end
        checks++; if (lat != AMT_W) begin errors++; $display("FAIL rm_fresh_latency got=%0d exp=%0d", lat, AMT_W); end
        checks++;
        if (out_data !== e[31:0] || out_carry !== e[32]) begin
            errors++; $display("FAIL rm_fresh_result got=%h c=%b exp=%h c=%b", out_data, out_carry, e[31:0], e[32]);
        end
        stale = 0;
        repeat (8) begin @(negedge clk); #1; if (out_valid) stale++; end
        checks++; if (stale != 0) begin errors++; $display("FAIL rm_stale got=%0d exp=0", stale); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
